// File: rtl/spi_flash_read_seq.sv
// SPI flash read sequencer: sends command, address and dummy bytes through a
// single-byte SPI engine, holds chip select for the whole transaction and streams the read bytes out.
module spi_flash_read_seq #(
   parameter logic [7:0] CMD_READ   = 8'h03,
   parameter int         ADDR_BYTES = 3,
   parameter int         LEN_WIDTH  = 16,
   parameter int         CS_GAP     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*ADDR_BYTES-1:0] addr,
   input  logic [LEN_WIDTH-1:0]    len,
   output logic                    busy,
   output logic                    done,
   output logic [7:0]              out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              spi_data,
   output logic                    spi_load,
   input  logic                    spi_busy,
   input  logic [7:0]              spi_rx,
   output logic                    cs
);

   // hdr_idx runs 0..ADDR_BYTES over the header and parks at ADDR_BYTES+1 for data
   localparam int HW = $clog2(ADDR_BYTES + 2);
   localparam int GW = $clog2(CS_GAP + 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOAD, WAIT_START, WAIT_DONE, OUTPUT, HOLD, DONE
   } state_t;

   state_t                  state_q, state_n;
   logic [GW-1:0]           gap_q, gap_n;
   logic [HW-1:0]           hdr_q, hdr_n;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_n, cnt_inc;
   logic [8*ADDR_BYTES-1:0] addr_q, addr_n;
   logic [LEN_WIDTH-1:0]    len_q, len_n;
   logic [7:0]              odata_q, odata_n;
   logic                    ovalid_q, ovalid_n;
   logic                    zdone_q, zdone_n;

   assign cnt_inc = cnt_q + LEN_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gap_q    <= '0;
         hdr_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         zdone_q  <= 1'b0;
      end else begin
         state_q  <= state_n;
         gap_q    <= gap_n;
         hdr_q    <= hdr_n;
         cnt_q    <= cnt_n;
         addr_q   <= addr_n;
         len_q    <= len_n;
         odata_q  <= odata_n;
         ovalid_q <= ovalid_n;
         zdone_q  <= zdone_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      gap_n    = gap_q;
      hdr_n    = hdr_q;
      cnt_n    = cnt_q;
      addr_n   = addr_q;
      len_n    = len_q;
      odata_n  = odata_q;
      ovalid_n = ovalid_q;
      zdone_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_n = SETUP;
                  addr_n  = addr;
                  len_n   = len;
                  hdr_n   = '0;
                  cnt_n   = '0;
                  gap_n   = '0;
               end else begin
                  zdone_n = 1'b1;
               end
            end
         end
         SETUP, HOLD: begin
            if (gap_q == GW'(CS_GAP - 1)) begin
               gap_n   = '0;
               state_n = (state_q == SETUP) ? LOAD : DONE;
            end else begin
               gap_n = gap_q + GW'(1);
            end
         end
         LOAD:       state_n = WAIT_START;
         WAIT_START: if (spi_busy) state_n = WAIT_DONE;
         WAIT_DONE: begin
            if (!spi_busy) begin
               if (hdr_q <= HW'(ADDR_BYTES)) begin
                  hdr_n   = hdr_q + HW'(1);
                  state_n = LOAD;
               end else begin
                  odata_n  = spi_rx;
                  ovalid_n = 1'b1;
                  state_n  = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            // link stays stalled with cs low until the consumer takes the byte
            if (out_ready) begin
               ovalid_n = 1'b0;
               cnt_n    = cnt_inc;
               state_n  = (cnt_inc == len_q) ? HOLD : LOAD;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      spi_data = 8'h00;
      if (state_q == LOAD) begin
         if (hdr_q == '0) spi_data = CMD_READ;
         for (int i = 1; i <= ADDR_BYTES; i++)
            if (hdr_q == HW'(i)) spi_data = addr_q[8*(ADDR_BYTES-i) +: 8];
      end
   end

   assign spi_load  = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign cs        = (state_q == IDLE) || (state_q == DONE);
   assign done      = (state_q == DONE) || zdone_q;
   assign out_data  = odata_q;
   assign out_valid = ovalid_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a simple byte-engine model
// (busy for six cycles after each load, received byte shown as busy drops).
module tb_spi_flash_read_seq;
   localparam int AB = 3, LW = 4, GAP = 4;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [23:0]   addr = '0;
   logic [LW-1:0] len = '0;
   logic          out_ready = 1'b0;
   logic          busy, done, out_valid, spi_load, cs;
   logic [7:0]    out_data, spi_data;
   logic          eng_busy = 1'b0;
   logic [7:0]    spi_rx = 8'h00, pend = 8'h00;
   int            eng_cnt = 0, ld_idx = 0;
   logic [7:0]    rsp [0:15];

   int            tests = 0, failed = 0;
   logic [7:0]    sent[$], beats[$];
   int            nloads = 0, done_cnt = 0, cs_low = 0, min_gap = -1;
   bit            seen_ld = 0, cs_low_seen = 0;

   spi_flash_read_seq #(.CMD_READ(8'h03), .ADDR_BYTES(AB), .LEN_WIDTH(LW), .CS_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .spi_data(spi_data), .spi_load(spi_load),
      .spi_busy(eng_busy), .spi_rx(spi_rx), .cs(cs));

   always #5 clk = ~clk;

   // engine model: header loads return junk, data loads return rsp[n]
   always @(posedge clk) begin
      if (rst) begin
         eng_busy <= 1'b0;
         eng_cnt  <= 0;
         ld_idx   <= 0;
      end else begin
         if (cs) ld_idx <= 0;
         else if (spi_load) ld_idx <= ld_idx + 1;
         if (spi_load) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 6;
            pend     <= (ld_idx >= 4) ? rsp[4'(ld_idx - 4)] : 8'hC3;
         end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
               eng_busy <= 1'b0;
               spi_rx   <= pend;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (spi_load) begin
            sent.push_back(spi_data);
            nloads++;
         end
         if (out_valid && out_ready) beats.push_back(out_data);
         if (done) done_cnt++;
         if (cs) begin
            cs_low  = 0;
            seen_ld = 0;
         end else begin
            cs_low_seen = 1;
            if (spi_load && !seen_ld) begin
               min_gap = cs_low;
               seen_ld = 1;
            end
            cs_low++;
         end
      end
   end

   task automatic clr();
      sent.delete();
      beats.delete();
      nloads = 0;
      done_cnt = 0;
      min_gap = -1;
      cs_low_seen = 0;
   endtask

   task automatic do_start(input logic [23:0] a, input logic [LW-1:0] l);
      @(posedge clk); #1;
      addr = a; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (cs !== 1'b1)         begin failed++; $display("FAIL rst_cs got %b want 1", cs); end
      tests++; if (busy !== 1'b0)       begin failed++; $display("FAIL rst_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0)       begin failed++; $display("FAIL rst_done got %b want 0", done); end
      tests++; if (spi_load !== 1'b0)   begin failed++; $display("FAIL rst_load got %b want 0", spi_load); end
      tests++; if (spi_data !== 8'h00)  begin failed++; $display("FAIL rst_spi_data got %h want 00", spi_data); end
      tests++; if (out_valid !== 1'b0)  begin failed++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      tests++; if (out_data !== 8'h00)  begin failed++; $display("FAIL rst_out_data got %h want 00", out_data); end
      rst = 1'b0;
   endtask

   task automatic test_header();
      logic [7:0] exp_b [0:4] = '{8'h03, 8'h12, 8'hAB, 8'h34, 8'h00};
      bit ok;
      clr();
      out_ready = 1'b1;
      rsp[0] = 8'h77;
      do_start(24'h12AB34, 1);
      wait_done(300, ok);
      tests++; if (!ok) begin failed++; $display("FAIL hdr_done timeout"); end
      tests++; if (nloads != 5) begin failed++; $display("FAIL hdr_loads got %0d want 5", nloads); end
      if (sent.size() == 5)
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (sent[i] !== exp_b[i]) begin failed++; $display("FAIL hdr_byte%0d got %h want %h", i, sent[i], exp_b[i]); end
         end
      tests++; if (min_gap < GAP) begin failed++; $display("FAIL hdr_cs_gap got %0d want >=%0d", min_gap, GAP); end
      tests++;
      if (beats.size() != 1 || beats[0] !== 8'h77) begin
         failed++; $display("FAIL hdr_beat got n=%0d want 1 beat of 77", beats.size());
      end
   endtask

   task automatic test_data_return();
      logic [7:0] exp_b [0:2] = '{8'hA5, 8'h5A, 8'hFF};
      bit ok;
      clr();
      out_ready = 1'b1;
      rsp[0] = 8'hA5; rsp[1] = 8'h5A; rsp[2] = 8'hFF;
      do_start(24'h000100, 3);
      wait_done(600, ok);
      tests++; if (!ok) begin failed++; $display("FAIL data_done timeout"); end
      @(negedge clk);
      tests++; if (cs !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL data_after_done cs=%b busy=%b want 1/0", cs, busy); end
      repeat (5) @(negedge clk);
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL data_done_cnt got %0d want 1", done_cnt); end
      tests++; if (beats.size() != 3) begin failed++; $display("FAIL data_beats got %0d want 3", beats.size()); end
      if (beats.size() == 3)
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (beats[i] !== exp_b[i]) begin failed++; $display("FAIL data_beat%0d got %h want %h", i, beats[i], exp_b[i]); end
         end
      tests++;
      if (sent.size() != 7 || sent[4] !== 8'h00 || sent[5] !== 8'h00 || sent[6] !== 8'h00) begin
         failed++; $display("FAIL data_dummy n=%0d want 7 loads with 00 dummies", sent.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      int viol;
      bit ok;
      clr();
      out_ready = 1'b0;
      rsp[0] = 8'h11; rsp[1] = 8'h22;
      do_start(24'hABCDEF, 2);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      tests++; if (!ok) begin failed++; $display("FAIL bp_valid timeout"); end
      held = out_data;
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_data !== held || out_valid !== 1'b1 || spi_load !== 1'b0 || cs !== 1'b0) viol++;
      end
      tests++; if (viol != 0) begin failed++; $display("FAIL bp_stall got %0d bad cycles want 0", viol); end
      tests++; if (held !== 8'h11) begin failed++; $display("FAIL bp_first got %h want 11", held); end
      tests++; if (nloads != 5) begin failed++; $display("FAIL bp_loads_stall got %0d want 5", nloads); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(300, ok);
      tests++; if (!ok) begin failed++; $display("FAIL bp_done timeout"); end
      tests++;
      if (beats.size() != 2 || beats[0] !== 8'h11 || beats[1] !== 8'h22) begin
         failed++; $display("FAIL bp_beats n=%0d want 11,22", beats.size());
      end
      tests++; if (nloads != 6) begin failed++; $display("FAIL bp_loads got %0d want 6", nloads); end
   endtask

   task automatic test_len_zero();
      clr();
      out_ready = 1'b1;
      @(posedge clk); #1;
      addr = 24'h555555; len = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL len0_done done=%b busy=%b want 1/0", done, busy); end
      repeat (10) @(negedge clk);
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL len0_done_cnt got %0d want 1", done_cnt); end
      tests++; if (nloads != 0 || cs_low_seen) begin failed++; $display("FAIL len0_idle loads=%0d cs_low=%0d want 0/0", nloads, cs_low_seen); end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] exp_b [0:4] = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h00};
      bit ok;
      clr();
      out_ready = 1'b1;
      rsp[0] = 8'h99;
      do_start(24'h000102, 1);
      repeat (3) @(posedge clk);
      #1;
      addr = 24'hFFFFFF; len = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(300, ok);
      tests++; if (!ok) begin failed++; $display("FAIL sbusy_done timeout"); end
      tests++; if (sent.size() != 5) begin failed++; $display("FAIL sbusy_loads got %0d want 5", sent.size()); end
      if (sent.size() == 5)
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (sent[i] !== exp_b[i]) begin failed++; $display("FAIL sbusy_byte%0d got %h want %h", i, sent[i], exp_b[i]); end
         end
      repeat (20) @(negedge clk);
      tests++;
      if (beats.size() != 1 || beats[0] !== 8'h99 || nloads != 5 || done_cnt != 1) begin
         failed++; $display("FAIL sbusy_after beats=%0d loads=%0d dones=%0d want 1/5/1", beats.size(), nloads, done_cnt);
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      clr();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) rsp[i] = 8'(i + 1);
      do_start(24'h333333, 5);
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (beats.size() == 2) begin ok = 1; break; end
      end
      tests++; if (!ok) begin failed++; $display("FAIL abort_two_beats timeout"); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (cs !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failed++; $display("FAIL abort_state cs=%b ov=%b busy=%b want 1/0/0", cs, out_valid, busy);
      end
      repeat (30) @(negedge clk);
      tests++; if (done_cnt != 0) begin failed++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
      clr();
      rsp[0] = 8'h61; rsp[1] = 8'h62;
      do_start(24'h010203, 2);
      wait_done(400, ok);
      tests++; if (!ok) begin failed++; $display("FAIL abort_fresh_done timeout"); end
      tests++;
      if (beats.size() != 2 || beats[0] !== 8'h61 || beats[1] !== 8'h62) begin
         failed++; $display("FAIL abort_fresh_beats n=%0d want 61,62", beats.size());
      end
   endtask

   task automatic test_max_count();
      bit ok;
      clr();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) rsp[i] = 8'(8'h40 + i);
      do_start(24'h0F0F0F, 4'hF);
      wait_done(3000, ok);
      tests++; if (!ok) begin failed++; $display("FAIL max_done timeout"); end
      repeat (5) @(negedge clk);
      tests++; if (beats.size() != 15) begin failed++; $display("FAIL max_beats got %0d want 15", beats.size()); end
      if (beats.size() == 15)
         for (int i = 0; i < 15; i++) begin
            tests++;
            if (beats[i] !== 8'(8'h40 + i)) begin failed++; $display("FAIL max_beat%0d got %h want %h", i, beats[i], 8'(8'h40 + i)); end
         end
      tests++; if (done_cnt != 1 || nloads != 19) begin failed++; $display("FAIL max_tail dones=%0d loads=%0d want 1/19", done_cnt, nloads); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rsp[i] = 8'h00;
      test_reset();
      test_header();
      repeat (2) @(posedge clk);
      test_data_return();
      test_backpressure();
      repeat (2) @(posedge clk);
      test_len_zero();
      test_start_while_busy();
      test_reset_abort();
      repeat (2) @(posedge clk);
      test_max_count();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
